// File: rtl/tp_decode_scheduler.sv
// tp_decode_scheduler: sequences one shared BM/Chien engine over a frame.
// Hard mode runs a single pass (tp 0). Soft mode runs tp1..tp4 in order,
// stops early on a clean pass, otherwise picks the lowest-metric good pattern.
// Optional feature macro: TP_STATS_EN adds saturating frame/early/fail counters.
module tp_decode_scheduler #(
  parameter int unsigned MW      = 10,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned OUT_GAP = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_mode,
  output logic          o_eng_start,
  output logic [2:0]    o_eng_tp,
  input  logic          i_eng_done,
  input  logic [2:0]    i_eng_num_err,
  input  logic          i_eng_fail,
  input  logic [MW-1:0] i_eng_metric,
  output logic [2:0]    o_select_tp,
  output logic          o_sel_valid,
  output logic          o_early_stop_pulse,
  output logic [2:0]    o_early_stop_tp,
`ifdef TP_STATS_EN
  output logic [15:0]   o_frame_cnt,
  output logic [15:0]   o_early_cnt,
  output logic [15:0]   o_fail_cnt,
`endif
  output logic          o_busy
);

  localparam int unsigned CMAX = (TIMEOUT > OUT_GAP) ? TIMEOUT : OUT_GAP;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DECIDE, S_DRAIN} state_t;

  state_t                state, state_nx;
  logic                  mode, mode_nx;
  logic [2:0]            tp, tp_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [3:0]            fail_st, fail_st_nx;
  logic [3:0][MW-1:0]    metric_st, metric_st_nx;
  logic [1:0]            slot;

  logic                  done_ev, tmo_ev, pass_end, pass_fail, pass_clean;
  logic                  found;
  logic [MW-1:0]         best;
  logic [2:0]            win;

  logic                  eng_start_nx, sel_valid_nx, early_nx, busy_nx;
  logic [2:0]            eng_tp_nx, select_tp_nx, early_tp_nx;

  // A pass ends on done, or on timeout when no done arrives; done wins a tie.
  assign done_ev    = (state == S_WAIT) && i_eng_done;
  assign tmo_ev     = (state == S_WAIT) && !i_eng_done && (cnt == CW'(TIMEOUT - 1));
  assign pass_end   = done_ev || tmo_ev;
  assign pass_fail  = done_ev ? i_eng_fail : 1'b1;
  assign pass_clean = done_ev && !i_eng_fail && (i_eng_num_err == 3'd0);
  assign slot       = tp[1:0] - 2'd1;

  // State and per-frame datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      mode      <= 1'b0;
      tp        <= '0;
      cnt       <= '0;
      fail_st   <= '0;
      metric_st <= '0;
    end else begin
      state     <= state_nx;
      mode      <= mode_nx;
      tp        <= tp_nx;
      cnt       <= cnt_nx;
      fail_st   <= fail_st_nx;
      metric_st <= metric_st_nx;
    end
  end

  // Next-state logic, pattern sequencing and per-pattern result capture.
  always_comb begin
    state_nx     = state;
    mode_nx      = mode;
    tp_nx        = tp;
    fail_st_nx   = fail_st;
    metric_st_nx = metric_st;
    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nx = S_LAUNCH;
          mode_nx  = i_mode;
          tp_nx    = i_mode ? 3'd1 : 3'd0;
        end
      end
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT: begin
        if (pass_end) begin
          if (!mode || pass_clean) begin
            state_nx = S_DRAIN;
          end else begin
            fail_st_nx[slot]   = pass_fail;
            metric_st_nx[slot] = done_ev ? i_eng_metric : '0;
            if (tp == 3'd4) begin
              state_nx = S_DECIDE;
            end else begin
              tp_nx    = tp + 3'd1;
              state_nx = S_LAUNCH;
            end
          end
        end
      end
      S_DECIDE: state_nx = S_DRAIN;
      S_DRAIN: begin
        if (cnt == CW'(OUT_GAP - 1)) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // One counter serves both the WAIT timeout and the DRAIN gap; it restarts on every state entry.
    cnt_nx = ((state_nx != state) || (state == S_IDLE)) ? '0 : cnt + 1'b1;
  end

  // Output next-values, including the winner pick used in DECIDE.
  always_comb begin
    found = 1'b0;
    best  = '0;
    win   = 3'd1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!fail_st[i] && (!found || (metric_st[i] < best))) begin
        found = 1'b1;
        best  = metric_st[i];
        win   = 3'(i + 1);
      end
    end
    eng_start_nx = (state_nx == S_LAUNCH);
    eng_tp_nx    = (state_nx == S_LAUNCH) ? tp_nx : o_eng_tp;
    sel_valid_nx = 1'b0;
    select_tp_nx = o_select_tp;
    early_nx     = 1'b0;
    early_tp_nx  = o_early_stop_tp;
    busy_nx      = (state_nx != S_IDLE);
    if (pass_end && !mode) begin
      sel_valid_nx = 1'b1;
      select_tp_nx = 3'd0;
    end
    if (pass_clean && mode) begin
      early_nx    = 1'b1;
      early_tp_nx = tp;
    end
    if (state == S_DECIDE) begin
      sel_valid_nx = 1'b1;
      select_tp_nx = win;
    end
  end

  // Registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_eng_start        <= 1'b0;
      o_eng_tp           <= '0;
      o_select_tp        <= '0;
      o_sel_valid        <= 1'b0;
      o_early_stop_pulse <= 1'b0;
      o_early_stop_tp    <= '0;
      o_busy             <= 1'b0;
    end else begin
      o_eng_start        <= eng_start_nx;
      o_eng_tp           <= eng_tp_nx;
      o_select_tp        <= select_tp_nx;
      o_sel_valid        <= sel_valid_nx;
      o_early_stop_pulse <= early_nx;
      o_early_stop_tp    <= early_tp_nx;
      o_busy             <= busy_nx;
    end
  end

`ifdef TP_STATS_EN
  // Saturating frame statistics; a frame counts when its single result pulse is issued.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_frame_cnt <= '0;
      o_early_cnt <= '0;
      o_fail_cnt  <= '0;
    end else begin
      if ((sel_valid_nx || early_nx) && (o_frame_cnt != '1)) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (early_nx && (o_early_cnt != '1)) o_early_cnt <= o_early_cnt + 16'd1;
      if ((state == S_DECIDE) && (&fail_st) && (o_fail_cnt != '1)) o_fail_cnt <= o_fail_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tp_decode_scheduler.sv
// Testbench for tp_decode_scheduler: the bench plays the shared engine,
// predicts each frame's outcome from the selection rules, and compares.
module tb_tp_decode_scheduler;
  localparam int unsigned MW      = 10;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned OUT_GAP = 8;
  localparam int          BUDGET  = 3000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          eng_done = 1'b0;
  logic [2:0]    eng_num_err = '0;
  logic          eng_fail = 1'b0;
  logic [MW-1:0] eng_metric = '0;
  logic          eng_start, sel_valid, early_pulse, busy;
  logic [2:0]    eng_tp, select_tp, early_tp;
`ifdef TP_STATS_EN
  logic [15:0]   frame_cnt, early_cnt, fail_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int smp = 0;

  // Engine responses per tp (index 0 = hard pass); dly 0 means never done.
  int r_fail[5], r_err[5], r_met[5], r_dly[5];
  // Observations of one frame.
  int g_launch[$], g_lsmp[$], g_dsmp[$];
  int sv_cnt, ob_sv_tp, es_cnt, ob_es_tp, pulse_smp, busy_len, last_done, start_smp, hung;
  // Expectations of one frame.
  int e_launch[$];
  int e_sv, e_es, e_tp, e_lat, e_allfail;
  int m_frames = 0, m_early = 0, m_fail = 0;

  tp_decode_scheduler #(.MW(MW), .TIMEOUT(TIMEOUT), .OUT_GAP(OUT_GAP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
    .o_eng_start(eng_start), .o_eng_tp(eng_tp),
    .i_eng_done(eng_done), .i_eng_num_err(eng_num_err), .i_eng_fail(eng_fail), .i_eng_metric(eng_metric),
    .o_select_tp(select_tp), .o_sel_valid(sel_valid),
    .o_early_stop_pulse(early_pulse), .o_early_stop_tp(early_tp),
`ifdef TP_STATS_EN
    .o_frame_cnt(frame_cnt), .o_early_cnt(early_cnt), .o_fail_cnt(fail_cnt),
`endif
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    smp++;
  endtask

  function automatic string qstr(input int q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  // Reference outcome: hard is always one pass on tp0; soft stops at the first
  // clean pass, else the smallest (metric, tp) among non-failed passes wins.
  function automatic void predict(input logic m);
    int cand[$];
    e_launch.delete();
    e_allfail = 0;
    m_frames++;
    if (!m) begin
      e_launch.push_back(0);
      e_sv = 1; e_es = 0; e_tp = 0; e_lat = 1;
      return;
    end
    for (int t = 1; t <= 4; t++) begin
      e_launch.push_back(t);
      if (r_dly[t] > 0 && r_fail[t] == 0 && r_err[t] == 0) begin
        e_sv = 0; e_es = 1; e_tp = t; e_lat = 1;
        m_early++;
        return;
      end
    end
    for (int t = 1; t <= 4; t++)
      if (r_dly[t] > 0 && r_fail[t] == 0) cand.push_back(r_met[t] * 8 + t);
    e_sv = 1; e_es = 0; e_lat = 2;
    if (cand.size() == 0) begin
      e_tp = 1; e_allfail = 1; m_fail++;
    end else begin
      cand.sort();
      e_tp = cand[0] % 8;
    end
  endfunction

  // Plays the engine for one frame and records what the DUT did.
  task automatic run_frame(input logic m, input bit noise, input bit stray);
    int due, n, cur;
    g_launch.delete(); g_lsmp.delete(); g_dsmp.delete();
    sv_cnt = 0; ob_sv_tp = -1; es_cnt = 0; ob_es_tp = -1; pulse_smp = -1;
    busy_len = 0; last_done = -1; hung = 0; due = -1; n = 0; cur = 0;
    mode = m; start = 1'b1; start_smp = smp;
    tick();
    start = 1'b0;
    forever begin
      eng_done = 1'b0; eng_fail = 1'b0; eng_num_err = '0; eng_metric = '0;
      if (eng_start) begin
        cur = int'(eng_tp);
        g_launch.push_back(cur); g_lsmp.push_back(smp); last_done = -1;
        due = (cur <= 4 && r_dly[cur] > 0) ? smp + r_dly[cur] : -1;
      end
      if (smp == due) begin
        eng_done = 1'b1; eng_fail = (r_fail[cur] != 0);
        eng_num_err = 3'(r_err[cur]); eng_metric = MW'(r_met[cur]);
        last_done = smp; g_dsmp.push_back(smp); due = -1;
      end
      if (sel_valid) begin sv_cnt++; ob_sv_tp = int'(select_tp); if (pulse_smp < 0) pulse_smp = smp; end
      if (early_pulse) begin es_cnt++; ob_es_tp = int'(early_tp); if (pulse_smp < 0) pulse_smp = smp; end
      if (stray && pulse_smp >= 0 && smp == pulse_smp + 2) begin
        eng_done = 1'b1; eng_fail = 1'b0; eng_num_err = '0;
      end
      if (!busy) break;
      if (pulse_smp >= 0) busy_len++;
      start = noise && (($urandom_range(0, 1) == 1) || (pulse_smp >= 0 && smp == pulse_smp + int'(OUT_GAP) - 1));
      n++;
      if (n > BUDGET) begin hung = 1; break; end
      tick();
    end
    start = 1'b0; eng_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({eng_start, eng_tp, select_tp, sel_valid, early_pulse, early_tp, busy} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0", {eng_start, eng_tp, select_tp, sel_valid, early_pulse, early_tp, busy});
    end
`ifdef TP_STATS_EN
    checks++;
    if ({frame_cnt, early_cnt, fail_cnt} !== 48'd0) begin
      failures++; $display("FAIL reset_stats: got %h required 0", {frame_cnt, early_cnt, fail_cnt});
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_hard();
    r_fail[0] = 0; r_err[0] = 2; r_met[0] = 77; r_dly[0] = 5;
    predict(1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    checks++;
    if (qstr(g_launch) != "0 ") begin failures++; $display("FAIL hard_launch: got '%s' required '0 '", qstr(g_launch)); end
    checks++;
    if (g_lsmp.size() < 1 || g_lsmp[0] - start_smp != 1) begin failures++; $display("FAIL hard_start_lat: launches %0d required start latency 1", g_lsmp.size()); end
    checks++;
    if (sv_cnt != 1 || ob_sv_tp != 0 || es_cnt != 0) begin
      failures++; $display("FAIL hard_result: sel_valid x%0d tp %0d early x%0d required 1/0/0", sv_cnt, ob_sv_tp, es_cnt);
    end
    checks++;
    if (pulse_smp - last_done != 1) begin failures++; $display("FAIL hard_latency: got %0d required 1", pulse_smp - last_done); end
    checks++;
    if (busy_len != int'(OUT_GAP) || hung != 0) begin failures++; $display("FAIL hard_drain: busy %0d hung %0d required %0d/0", busy_len, hung, OUT_GAP); end
  endtask

  task automatic test_soft_order();
    int gaps_ok;
    r_met[1] = 40; r_met[2] = 25; r_met[3] = 25; r_met[4] = 60;
    for (int t = 1; t <= 4; t++) begin r_fail[t] = 0; r_err[t] = 1; r_dly[t] = $urandom_range(1, 6); end
    predict(1'b1);
    run_frame(1'b1, 1'b0, 1'b0);
    checks++;
    if (qstr(g_launch) != "1 2 3 4 ") begin failures++; $display("FAIL soft_launch: got '%s' required '1 2 3 4 '", qstr(g_launch)); end
    gaps_ok = (g_lsmp.size() == 4 && g_dsmp.size() == 4);
    for (int i = 1; i < 4; i++) if (gaps_ok && g_lsmp[i] - g_dsmp[i-1] != 1) gaps_ok = 0;
    checks++;
    if (gaps_ok != 1) begin failures++; $display("FAIL soft_relaunch_lat: got ok=%0d required 1", gaps_ok); end
    checks++;
    if (sv_cnt != 1 || ob_sv_tp != 2 || es_cnt != 0) begin
      failures++; $display("FAIL soft_tie_low: sel_valid x%0d tp %0d early x%0d required 1/2/0", sv_cnt, ob_sv_tp, es_cnt);
    end
    checks++;
    if (pulse_smp - last_done != 2) begin failures++; $display("FAIL soft_decide_lat: got %0d required 2", pulse_smp - last_done); end
  endtask

  task automatic test_early_stop();
    r_fail[1] = 0; r_err[1] = 1; r_met[1] = 9; r_dly[1] = 3;
    r_fail[2] = 0; r_err[2] = 0; r_met[2] = 500; r_dly[2] = 4;
    for (int t = 3; t <= 4; t++) begin r_fail[t] = 0; r_err[t] = 0; r_met[t] = 1; r_dly[t] = 2; end
    predict(1'b1);
    run_frame(1'b1, 1'b0, 1'b0);
    checks++;
    if (qstr(g_launch) != "1 2 ") begin failures++; $display("FAIL early_launch: got '%s' required '1 2 '", qstr(g_launch)); end
    checks++;
    if (es_cnt != 1 || ob_es_tp != 2 || sv_cnt != 0) begin
      failures++; $display("FAIL early_result: early x%0d tp %0d sel_valid x%0d required 1/2/0", es_cnt, ob_es_tp, sv_cnt);
    end
    checks++;
    if (pulse_smp - last_done != 1) begin failures++; $display("FAIL early_latency: got %0d required 1", pulse_smp - last_done); end
    checks++;
    if (early_tp !== 3'd2) begin failures++; $display("FAIL early_tp_hold: got %0d required 2", early_tp); end
  endtask

  task automatic test_all_fail();
    for (int t = 1; t <= 4; t++) begin
      r_fail[t] = 1; r_err[t] = $urandom_range(0, 7); r_met[t] = $urandom_range(0, 1023); r_dly[t] = $urandom_range(1, 6);
    end
    predict(1'b1);
    run_frame(1'b1, 1'b0, 1'b0);
    checks++;
    if (qstr(g_launch) != "1 2 3 4 " || sv_cnt != 1 || ob_sv_tp != 1 || es_cnt != 0) begin
      failures++; $display("FAIL all_fail: launches '%s' sel_valid x%0d tp %0d early x%0d required 4 launches/1/1/0",
                           qstr(g_launch), sv_cnt, ob_sv_tp, es_cnt);
    end
  endtask

  task automatic test_timeout();
    int gap;
    r_fail[1] = 0; r_err[1] = 1; r_met[1] = 300; r_dly[1] = 2;
    r_fail[2] = 0; r_err[2] = 2; r_met[2] = 200; r_dly[2] = 3;
    r_fail[3] = 0; r_err[3] = 1; r_met[3] = 0;   r_dly[3] = 0;
    r_fail[4] = 0; r_err[4] = 3; r_met[4] = 100; r_dly[4] = 4;
    predict(1'b1);
    run_frame(1'b1, 1'b0, 1'b0);
    checks++;
    if (qstr(g_launch) != "1 2 3 4 ") begin failures++; $display("FAIL timeout_launch: got '%s' required '1 2 3 4 '", qstr(g_launch)); end
    gap = (g_lsmp.size() >= 4) ? g_lsmp[3] - g_lsmp[2] : -1;
    checks++;
    if (gap < int'(TIMEOUT) || gap > int'(TIMEOUT) + 2) begin
      failures++; $display("FAIL timeout_gap: got %0d required %0d..%0d", gap, TIMEOUT, TIMEOUT + 2);
    end
    checks++;
    if (sv_cnt != 1 || ob_sv_tp != e_tp) begin failures++; $display("FAIL timeout_winner: sel_valid x%0d tp %0d required 1/%0d", sv_cnt, ob_sv_tp, e_tp); end
  endtask

  task automatic test_protocol();
    int extra;
    r_fail[0] = 0; r_err[0] = 1; r_met[0] = 5; r_dly[0] = 3;
    predict(1'b0);
    run_frame(1'b0, 1'b1, 1'b1);
    checks++;
    if (qstr(g_launch) != "0 " || sv_cnt != 1 || es_cnt != 0 || busy_len != int'(OUT_GAP)) begin
      failures++; $display("FAIL protocol_frame: launches '%s' sel_valid x%0d early x%0d busy %0d required '0 '/1/0/%0d",
                           qstr(g_launch), sv_cnt, es_cnt, busy_len, OUT_GAP);
    end
    extra = 0;
    repeat (4) begin tick(); extra += int'(eng_start) + int'(busy) + int'(sel_valid); end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL protocol_dropped_start: activity %0d required 0", extra); end
    predict(1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    checks++;
    if (qstr(g_launch) != "0 " || sv_cnt != 1 || ob_sv_tp != 0) begin
      failures++; $display("FAIL protocol_next_start: launches '%s' sel_valid x%0d tp %0d required '0 '/1/0", qstr(g_launch), sv_cnt, ob_sv_tp);
    end
  endtask

  task automatic test_reset_abort();
    int n, act;
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!eng_start && n < 20) begin tick(); n++; end
    checks++;
    if (eng_start !== 1'b1) begin failures++; $display("FAIL abort_launch: got %b required 1", eng_start); end
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({eng_start, eng_tp, select_tp, sel_valid, early_pulse, early_tp, busy} !== 13'd0) begin
      failures++; $display("FAIL abort_outputs: got %b required 0", {eng_start, eng_tp, select_tp, sel_valid, early_pulse, early_tp, busy});
    end
    rst_n = 1'b1;
    m_frames = 0; m_early = 0; m_fail = 0;
    act = 0;
    repeat (20) begin tick(); act += int'(sel_valid) + int'(early_pulse) + int'(eng_start) + int'(busy); end
    checks++;
    if (act != 0) begin failures++; $display("FAIL abort_no_pulse: activity %0d required 0", act); end
  endtask

  task automatic test_random_frames();
    logic m;
    bit noise, stray;
    for (int f = 0; f < 25; f++) begin
      m = 1'($urandom_range(0, 1));
      for (int t = 0; t <= 4; t++) begin
        r_fail[t] = ($urandom_range(0, 3) == 0);
        r_err[t]  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 7));
        r_met[t]  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1023));
        r_dly[t]  = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6));
      end
      noise = 1'($urandom_range(0, 1));
      stray = 1'($urandom_range(0, 1));
      predict(m);
      run_frame(m, noise, stray);
      checks++;
      if (qstr(g_launch) != qstr(e_launch)) begin
        failures++; $display("FAIL rnd%0d_launch: got '%s' required '%s'", f, qstr(g_launch), qstr(e_launch));
      end
      checks++;
      if (sv_cnt != e_sv || es_cnt != e_es) begin
        failures++; $display("FAIL rnd%0d_pulses: sel_valid x%0d early x%0d required %0d/%0d", f, sv_cnt, es_cnt, e_sv, e_es);
      end
      checks++;
      if ((e_sv == 1 ? ob_sv_tp : ob_es_tp) != e_tp) begin
        failures++; $display("FAIL rnd%0d_tp: got %0d required %0d", f, (e_sv == 1 ? ob_sv_tp : ob_es_tp), e_tp);
      end
      if (last_done >= 0) begin
        checks++;
        if (pulse_smp - last_done != e_lat) begin
          failures++; $display("FAIL rnd%0d_latency: got %0d required %0d", f, pulse_smp - last_done, e_lat);
        end
      end
      checks++;
      if (busy_len != int'(OUT_GAP) || hung != 0) begin
        failures++; $display("FAIL rnd%0d_drain: busy %0d hung %0d required %0d/0", f, busy_len, hung, OUT_GAP);
      end
    end
`ifdef TP_STATS_EN
    checks++;
    if (frame_cnt != 16'(m_frames) || early_cnt != 16'(m_early) || fail_cnt != 16'(m_fail)) begin
      failures++; $display("FAIL stats: got %0d/%0d/%0d required %0d/%0d/%0d",
                           frame_cnt, early_cnt, fail_cnt, m_frames, m_early, m_fail);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_hard();
    test_soft_order();
    test_early_stop();
    test_all_fail();
    test_timeout();
    test_protocol();
    test_reset_abort();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
